// File: rtl/window_gen_3x3.sv
// Raster-to-3x3 window generator feeding the Sobel stage.
// Optional WINDOW_SOF_EN adds a sof input that restarts the frame at (0,0).
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [`WORD_SIZE-1:0] data_in,
`ifdef WINDOW_SOF_EN
  input  logic                  sof,
`endif
  output logic [`WORD_SIZE-1:0] p1,
  output logic [`WORD_SIZE-1:0] p2,
  output logic [`WORD_SIZE-1:0] p3,
  output logic [`WORD_SIZE-1:0] p4,
  output logic [`WORD_SIZE-1:0] p5,
  output logic [`WORD_SIZE-1:0] p6,
  output logic [`WORD_SIZE-1:0] p7,
  output logic [`WORD_SIZE-1:0] p8,
  output logic [`WORD_SIZE-1:0] p9,
  output logic                  out_valid,
  output logic [15:0]           out_x,
  output logic [15:0]           out_y,
  output logic                  eof
);

  localparam int W  = `WORD_SIZE;
  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

  logic [W-1:0] lb1 [IMG_WIDTH];
  logic [W-1:0] lb2 [IMG_WIDTH];

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [W-1:0]  lb1_q;
  logic [W-1:0]  lb2_q;
  logic          last_col;
  logic          last_row;
  logic          win_ok;

  // Position of the pixel presented this cycle; sof overrides the counters.
  always_comb begin
    cur_col = col;
    cur_row = row;
`ifdef WINDOW_SOF_EN
    if (sof) begin
      cur_col = '0;
      cur_row = '0;
    end
`endif
  end

  assign lb1_q    = lb1[cur_col];
  assign lb2_q    = lb2[cur_col];
  assign last_col = (cur_col == CW'(IMG_WIDTH - 1));
  assign last_row = (cur_row == RW'(IMG_HEIGHT - 1));
  assign win_ok   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  // Line buffers carry no reset; their stale contents never reach out_valid.
  always_ff @(posedge clk) begin
    if (!reset && in_valid) begin
      lb2[cur_col] <= lb1_q;
      lb1[cur_col] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
      p4        <= '0;
      p5        <= '0;
      p6        <= '0;
      p7        <= '0;
      p8        <= '0;
      p9        <= '0;
      out_valid <= 1'b0;
      eof       <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= 1'b0;
      eof       <= 1'b0;
      if (in_valid) begin
        p1 <= p2;
        p2 <= p3;
        p3 <= lb2_q;
        p4 <= p5;
        p5 <= p6;
        p6 <= lb1_q;
        p7 <= p8;
        p8 <= p9;
        p9 <= data_in;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
        if (win_ok) begin
          out_valid <= 1'b1;
          eof       <= last_col && last_row;
          out_x     <= 16'(cur_col) - 16'd1;
          out_y     <= 16'(cur_row) - 16'd1;
        end
      end
    end
  end

endmodule
